// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing.
package uart_tx_arbiter_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ACK_TIMEOUT = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_LOAD      = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester strictly after 'last', wrapping.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int          j;
    logic [IW-1:0] j_idx;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(last) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IW'(j);
      if (!found && req[j_idx]) begin
        found        = 1'b1;
        grant[j_idx] = 1'b1;
        idx          = j_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter feeding one byte at a time into a single uart_tx.
//
// state        | meaning
// IDLE         | no grant; waiting for any req_valid
// ARB          | round-robin pick after last_grant
// LOAD         | grant held; accept next byte when valid and uart idle
// START        | one-cycle tx_start, arm ack timer
// WAIT_ACK     | waiting for tx_busy to rise, or timer expiry (tx_err)
// WAIT_DONE    | waiting for tx_busy to fall; continue message or release
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  localparam int IW         = idx_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [IW-1:0]        grant_id,
  output logic                 tx_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t               state, state_nxt;
  logic [IW-1:0]        last_grant;
  logic                 last_flag;
  logic [CW-1:0]        ack_cnt;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 accept;
  logic                 byte_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    byte_done = 1'b0;
    tx_start  = 1'b0;
    tx_err    = 1'b0;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (|req_valid) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        state_nxt = (|pick_grant) ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        if (req_valid[grant_id] && !tx_busy) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_start  = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (ack_cnt == '0) begin
          tx_err    = 1'b1;
          byte_done = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) byte_done = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A timed-out byte is retired exactly like a completed one.
    if (byte_done) state_nxt = last_flag ? ST_IDLE : ST_LOAD;

    // Strobes are suppressed during the reset cycle so an abort emits nothing.
    if (reset) begin
      accept    = 1'b0;
      byte_done = 1'b0;
      tx_start  = 1'b0;
      tx_err    = 1'b0;
    end
    req_ready[grant_id] = accept;
  end

  assign grant_active = (state == ST_LOAD) || (state == ST_START) ||
                        (state == ST_WAIT_ACK) || (state == ST_WAIT_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tx_data    <= 8'h00;
      grant_id   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      last_flag  <= 1'b0;
      ack_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ARB && |pick_grant) grant_id <= pick_idx;
      if (accept) begin
        tx_data   <= req_data[{grant_id, 3'b000} +: 8];
        last_flag <= req_last[grant_id];
      end
      // Down-counter: expires ACK_TIMEOUT cycles after the tx_start cycle.
      if (state == ST_START) begin
        ack_cnt <= CW'(ACK_TIMEOUT - 1);
      end else if (state == ST_WAIT_ACK && ack_cnt != '0) begin
        ack_cnt <= ack_cnt - 1'b1;
      end
      if (byte_done && last_flag) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench: message-level round-robin model plus a simple uart_tx responder.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx_start, tx_busy, grant_active, tx_err;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .tx_err       (tx_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] bq [N][$];
  logic       lq [N][$];
  logic [7:0] exp_byte [$];
  int         exp_id [$];
  int         pos [N];
  logic [N-1:0] xfer;
  int   acc_idx, start_idx, cyc, start_cyc, err_cnt;
  logic prev_ready, start_due, dead;
  int   stub_phase, stub_cnt, stub_hold_force;
  logic [7:0] stub_held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      lq[i].delete();
      pos[i] = 0;
    end
    exp_byte.delete();
    exp_id.delete();
    acc_idx = 0; start_idx = 0; err_cnt = 0;
    xfer = '0; prev_ready = 1'b0; start_due = 1'b0;
    stub_phase = 0; stub_cnt = 0; stub_hold_force = 0;
  endtask

  task automatic push_msg(input int r, input logic [7:0] b0, input int len);
    for (int k = 0; k < len; k++) begin
      bq[r].push_back(b0 + 8'(k));
      lq[r].push_back(k == len - 1);
    end
  endtask

  // Expected traffic: whole messages, requesters visited round-robin starting after N-1.
  task automatic build_expect();
    int p [N];
    int last_g, left, pick, c;
    logic done;
    last_g = N - 1;
    left = 0;
    for (int i = 0; i < N; i++) begin
      p[i] = 0;
      left += bq[i].size();
    end
    while (left > 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        c = (last_g + k) % N;
        if (pick < 0 && p[c] < bq[c].size()) pick = c;
      end
      done = 1'b0;
      while (!done) begin
        exp_byte.push_back(bq[pick][p[pick]]);
        exp_id.push_back(pick);
        done = lq[pick][p[pick]];
        p[pick]++;
        left--;
      end
      last_g = pick;
    end
  endtask

  task automatic step();
    logic first;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (xfer[i]) pos[i]++;
    if (stub_phase == 1) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        tx_busy = 1'b1;
        stub_phase = 2;
        stub_cnt = (stub_hold_force > 0) ? stub_hold_force : $urandom_range(1, 5);
      end
    end else if (stub_phase == 2) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        tx_busy = 1'b0;
        stub_phase = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pos[i] < bq[i].size()) begin
        first = (pos[i] == 0) || lq[i][pos[i] - 1];
        req_valid[i] = first || ($urandom_range(0, 3) != 0);
        req_data[8*i +: 8] = bq[i][pos[i]];
        req_last[i] = lq[i][pos[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    #1;
    if (req_ready != '0) begin
      chk("ready_onehot", {31'd0, $onehot(req_ready)}, 1);
      chk("ready_gap", {31'd0, prev_ready}, 0);
      if (acc_idx < exp_id.size()) chk("ready_who", {28'd0, req_ready}, 32'd1 << exp_id[acc_idx]);
      else chk("ready_extra", {28'd0, req_ready}, 0);
      acc_idx++;
    end
    prev_ready = (req_ready != '0);
    if (start_due) chk("start_latency", {31'd0, tx_start}, 1);
    start_due = (req_ready != '0);
    if (tx_start) begin
      if (start_idx < exp_byte.size()) begin
        chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_byte[start_idx]});
        chk("tx_gid", {30'd0, grant_id}, exp_id[start_idx]);
        chk("gact_on_start", {31'd0, grant_active}, 1);
      end else begin
        chk("spurious_start", {31'd0, tx_start}, 0);
      end
      start_idx++;
      start_cyc = cyc;
      stub_held = tx_data;
      if (!dead) begin
        stub_phase = 1;
        stub_cnt = $urandom_range(1, 4);
      end
    end
    if (dead) begin
      if (tx_err) begin
        err_cnt++;
        chk("err_delay", cyc - start_cyc, TO);
      end
    end else begin
      chk("no_err", {31'd0, tx_err}, 0);
    end
    if (tx_busy) chk("data_stable", {24'd0, tx_data}, {24'd0, stub_held});
    xfer = req_ready & req_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0;
    clear_all();
    @(negedge clk);
    #1;
    chk("rst_ready", {28'd0, req_ready}, 0);
    chk("rst_start", {31'd0, tx_start}, 0);
    chk("rst_data", {24'd0, tx_data}, 0);
    chk("rst_gact", {31'd0, grant_active}, 0);
    chk("rst_gid", {30'd0, grant_id}, 0);
    chk("rst_err", {31'd0, tx_err}, 0);
    reset = 1'b0;
  endtask

  task automatic run_phase(input int budget);
    int n;
    n = 0;
    build_expect();
    while (n < budget && !(start_idx == exp_byte.size() && acc_idx == exp_byte.size() &&
                           !grant_active && stub_phase == 0 && !tx_busy)) begin
      step();
      n++;
    end
    chk("phase_sent", start_idx, exp_byte.size());
    chk("phase_release", {31'd0, grant_active}, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; dead = 1'b0; cyc = 0; start_cyc = 0; stub_held = '0;
    req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0;
    clear_all();

    do_reset();
    push_msg(0, 8'hA5, 1);
    run_phase(200);

    do_reset();
    push_msg(1, 8'h11, 1);
    push_msg(2, 8'h22, 1);
    run_phase(200);

    do_reset();
    bq[0] = '{8'h48, 8'h49, 8'h0A};
    lq[0] = '{1'b0, 1'b0, 1'b1};
    push_msg(3, 8'h33, 1);
    run_phase(300);

    do_reset();
    for (int r = 0; r < N; r++) begin
      push_msg(r, 8'(8'h40 + r), 1);
      push_msg(r, 8'(8'h50 + r), 1);
    end
    run_phase(400);

    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int r = 0; r < N; r++) begin
        n = $urandom_range(0, 3);
        for (int m = 0; m < n; m++) push_msg(r, 8'($urandom), $urandom_range(1, 3));
      end
      run_phase(1500);
    end

    // Dead uart: every byte times out; multi-byte message must still complete.
    dead = 1'b1;
    do_reset();
    push_msg(0, 8'h7E, 1);
    run_phase(200);
    chk("err_count_single", err_cnt, 1);
    do_reset();
    push_msg(2, 8'h01, 2);
    run_phase(200);
    chk("err_count_multi", err_cnt, 2);
    dead = 1'b0;

    // Reset while requester 1 is in WAIT_DONE after requester 0 already finished.
    do_reset();
    push_msg(0, 8'h11, 1);
    push_msg(1, 8'h55, 1);
    build_expect();
    stub_hold_force = 20;
    n = 0;
    while (n < 300 && !(start_idx == 2 && tx_busy)) begin
      step();
      n++;
    end
    chk("reach_wait_done", start_idx, 2);
    step();
    @(negedge clk);
    reset = 1'b1;
    tx_busy = 1'b0;
    req_valid = '0;
    clear_all();
    @(posedge clk);
    #1;
    chk("abort_gact", {31'd0, grant_active}, 0);
    chk("abort_data", {24'd0, tx_data}, 0);
    chk("abort_gid", {30'd0, grant_id}, 0);
    chk("abort_start", {31'd0, tx_start}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("quiet_after_rst", {31'd0, tx_start}, 0);
    end
    push_msg(1, 8'hAA, 1);
    push_msg(0, 8'hBB, 1);
    run_phase(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters, 2..8 SHALL be supported.
REQ-002 Parameter ACK_TIMEOUT, 8, max cycles SHALL wait for tx_busy to rise after tx_start.
REQ-003 clk  input  1  system clock, 50 MHz; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  byte is final byte of requester's message.
REQ-008 req_ready  output  NUM_REQ  one-hot accept strobe; transfer on valid & ready.
REQ-009 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-010 tx_data  output  8  registered byte to uart_tx, stable from tx_start until tx_busy falls.
REQ-011 tx_busy  input  1  busy from uart_tx.
REQ-012 grant_active  output  1  a requester holds the UART (message lock).
REQ-013 grant_id  output  clog2(NUM_REQ)  index of granted requester, valid when grant_active.
REQ-014 tx_err  output  1  one-cycle pulse on ACK_TIMEOUT expiry.

Function
REQ-015 FSM states: IDLE, ARB, LOAD, START, WAIT_ACK, WAIT_DONE.
REQ-016 IDLE: grant_active=0; any req_valid -> ARB next cycle.
REQ-017 ARB: round-robin pick, search starting at last_grant+1 modulo NUM_REQ; set grant_id, grant_active=1, -> LOAD.
REQ-018 LOAD: when req_valid[grant_id]=1 and tx_busy=0, assert req_ready[grant_id] one cycle, capture byte into tx_data and req_last into last_flag, -> START; otherwise hold in LOAD indefinitely.
REQ-019 req_ready SHALL be at most one-hot, asserted only in LOAD, never two consecutive cycles.
REQ-020 START: tx_start=1 exactly one cycle, reset ack counter, -> WAIT_ACK.
REQ-021 WAIT_ACK: tx_busy=1 -> WAIT_DONE; counter reaching ACK_TIMEOUT -> pulse tx_err, treat byte as done.
REQ-022 WAIT_DONE: on tx_busy=0, if last_flag=0 -> LOAD (same grant), else update last_grant=grant_id, clear grant_active, -> IDLE.
REQ-023 Lock: non-granted requesters SHALL never see req_ready while a message is in progress, regardless of their valid.
REQ-024 Granted requester dropping req_valid mid-message: arbiter holds grant in LOAD (no timeout); requester responsibility.
REQ-025 Simultaneous requests in ARB: lowest index at/after last_grant+1 wins; non-requesting indices skipped.
REQ-026 Byte-to-byte latency: req_ready -> tx_start 1 cycle; tx_busy fall -> next req_ready 1 cycle minimum.
REQ-027 tx_err timeout byte with last_flag=0 continues to LOAD; with last_flag=1 releases grant.

Reset
REQ-028 On reset: state IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_active=0, grant_id=0, tx_err=0, last_flag=0, ack counter=0.
REQ-029 On reset last_grant=NUM_REQ-1 so requester 0 wins first arbitration.
REQ-030 Reset mid-message SHALL abort immediately; no tx_start after reset deasserts until new request.

Structure
REQ-031 Shared package holds FSM state encoding and default NUM_REQ/ACK_TIMEOUT constants.
REQ-032 Round-robin selector SHALL be a sub-module rr_pick (request vector, last index in; one-hot grant and index out, combinational).

Verification
REQ-033 After reset, req0 sends 0xA5 last=1 -> one req_ready[0] pulse, tx_start one cycle with tx_data=0xA5, grant_active drops after tx_busy falls.
REQ-034 req1=0x11, req2=0x22 asserted same cycle, last=1 -> 0x11 transmitted first, then 0x22.
REQ-035 req0 message 0x48,0x49,0x0A (last on 0x0A) with req3=0x33 pending from start -> tx order 0x48,0x49,0x0A,0x33; req_ready[3] never during req0 message.
REQ-036 All four requesters continuously valid with single-byte messages -> grant_id order 0,1,2,3,0,1.
REQ-037 Reset asserted during WAIT_DONE of byte 0x55 -> all outputs reset next edge; next grant goes to requester 0.
REQ-038 tx_busy tied 0, req0 sends 0x7E -> tx_err pulses ACK_TIMEOUT cycles after tx_start (8 default), grant released.
